// File: rtl/mux4_scan_sequencer.sv
// Drives a 4:1 bit mux with a latched word, steps its select through all four
// positions with a programmable settle time, and streams the sampled bits out.
module mux4_scan_sequencer #(
  parameter int unsigned DWELL     = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  output logic [3:0] mux_in,
  output logic [1:0] mux_sel,
  input  logic       mux_out,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for a word, word_ready high
  // SETTLE | mux select applied, counting down the settle time
  // HOLD   | sampled bit presented, waiting for ser_ready

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [1:0] SEL_START = MSB_FIRST ? 2'b11 : 2'b00;
  localparam logic [3:0] CNT_LOAD  = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] mux_in_q, mux_in_d;
  logic [1:0] mux_sel_q, mux_sel_d;
  logic       ser_bit_q, ser_bit_d;
  logic       ser_valid_q, ser_valid_d;
  logic       ser_last_q, ser_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      mux_in_q    <= '0;
      mux_sel_q   <= SEL_START;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mux_in_q    <= mux_in_d;
      mux_sel_q   <= mux_sel_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mux_in_d    = mux_in_q;
    mux_sel_d   = mux_sel_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
    case (state_q)
      IDLE: begin
        if (word_valid) begin
          mux_in_d  = word_in;
          mux_sel_d = SEL_START;
          cnt_d     = CNT_LOAD;
          idx_d     = 2'd0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          ser_bit_d   = mux_out;
          ser_valid_d = 1'b1;
          ser_last_d  = (idx_q == 2'd3);
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (ser_ready) begin
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
          if (ser_last_q) begin
            state_d = IDLE;
          end else begin
            // idx_q counts positions; mux_sel_q just follows the scan direction
            mux_sel_d = MSB_FIRST ? (mux_sel_q - 2'd1) : (mux_sel_q + 2'd1);
            idx_d     = idx_q + 2'd1;
            cnt_d     = CNT_LOAD;
            state_d   = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mux_in     = mux_in_q;
  assign mux_sel    = mux_sel_q;
  assign ser_bit    = ser_bit_q;
  assign ser_valid  = ser_valid_q;
  assign ser_last   = ser_last_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer: an LSB-first DWELL=1 instance and an MSB-first
// DWELL=3 instance, each closed through a behavioural 4:1 mux.
module tb_mux4_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] word_in = 4'b0;
  logic       word_valid_a = 1'b0, word_valid_b = 1'b0;
  logic       ser_ready = 1'b1;

  logic       rdy_a, rdy_b, busy_a, busy_b;
  logic [3:0] mi_a, mi_b;
  logic [1:0] ms_a, ms_b;
  logic       mo_a, mo_b;
  logic       sb_a, sb_b, sv_a, sv_b, sl_a, sl_b;

  always #5 clk = ~clk;

  assign mo_a = mi_a[ms_a];
  assign mo_b = mi_b[ms_b];

  mux4_scan_sequencer #(.DWELL(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid_a),
    .word_ready(rdy_a), .mux_in(mi_a), .mux_sel(ms_a), .mux_out(mo_a),
    .ser_bit(sb_a), .ser_valid(sv_a), .ser_last(sl_a), .ser_ready(ser_ready),
    .busy(busy_a));

  mux4_scan_sequencer #(.DWELL(3), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid_b),
    .word_ready(rdy_b), .mux_in(mi_b), .mux_sel(ms_b), .mux_out(mo_b),
    .ser_bit(sb_b), .ser_valid(sv_b), .ser_last(sl_b), .ser_ready(ser_ready),
    .busy(busy_b));

  logic       use_b = 1'b0;
  logic       o_ready, o_busy, o_bit, o_valid, o_last;
  logic [1:0] o_sel;
  logic [3:0] o_min;
  assign o_ready = use_b ? rdy_b  : rdy_a;
  assign o_busy  = use_b ? busy_b : busy_a;
  assign o_bit   = use_b ? sb_b   : sb_a;
  assign o_valid = use_b ? sv_b   : sv_a;
  assign o_last  = use_b ? sl_b   : sl_a;
  assign o_sel   = use_b ? ms_b   : ms_a;
  assign o_min   = use_b ? mi_b   : mi_a;

  typedef struct {
    logic       b;
    logic       lst;
    logic [1:0] sel;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] w;
    bit         on_b;
    logic [3:0] seq;   // emission order, seq[3] first
    int         cyc;
    int         lat;
  } vec_t;
  vec_t vt[4];

  int   total = 0;
  int   bad = 0;
  time  last_acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every handshaken bit is popped and compared
  always @(negedge clk) begin
    if (rst_n && o_valid && ser_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: unexpected bit=%0b sel=%0d at %0t", o_bit, o_sel, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({o_bit, o_last, o_sel} !== {e.b, e.lst, e.sel}) begin
          bad++;
          $display("FAIL sb_bit: got bit=%0b last=%0b sel=%0d expected bit=%0b last=%0b sel=%0d at %0t",
                   o_bit, o_last, o_sel, e.b, e.lst, e.sel, $time);
        end
      end
    end
  end

  task automatic push_frame(input logic [3:0] seq, input bit on_b);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.b   = seq[3-k];
      e.lst = (k == 3);
      e.sel = on_b ? 2'(3 - k) : 2'(k);
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input logic [3:0] w, input bit on_b, input logic [3:0] seq,
                           input int exp_cyc, input int exp_lat, input bit bp, input bit ign);
    int n;
    int lat;
    bit seen;
    bit done;
    bit bp_done;
    use_b = on_b;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    word_in = w;
    if (on_b) word_valid_b = 1'b1; else word_valid_a = 1'b1;
    push_frame(seq, on_b);
    @(posedge clk);
    last_acc = $time;
    #1;
    if (ign) word_in = ~w;
    else begin
      word_valid_a = 1'b0;
      word_valid_b = 1'b0;
    end
    n = 0; lat = 0; seen = 0; done = 0; bp_done = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ign && n == 4) begin
        word_valid_a = 1'b0;
        word_valid_b = 1'b0;
      end
      if (o_valid && !seen) begin
        seen = 1;
        lat  = n;
      end
      if (bp && !bp_done && o_valid && o_sel == 2'b01) begin
        ser_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          n++;
          #1;
          chk("bp_valid", 32'(o_valid), 32'd1);
          chk("bp_bit",   32'(o_bit),   32'd1);
          chk("bp_sel",   32'(o_sel),   32'd1);
        end
        ser_ready = 1'b1;
        bp_done   = 1;
      end
      if (o_ready) done = 1;
    end
    chk("frame_cycles", 32'(n), 32'(exp_cyc));
    chk("first_valid_lat", 32'(lat), 32'(exp_lat));
  endtask

  time t1;

  initial begin
    vt[0] = '{4'b1010, 1'b0, 4'b0101,  8, 1};
    vt[1] = '{4'b1000, 1'b1, 4'b1000, 16, 3};
    vt[2] = '{4'b0011, 1'b0, 4'b1100,  8, 1};
    vt[3] = '{4'b0110, 1'b1, 4'b0110, 16, 3};

    #12;
    chk("rst_ready_a", 32'(rdy_a), 32'd1);
    chk("rst_busy_a",  32'(busy_a), 32'd0);
    chk("rst_valid_a", 32'(sv_a), 32'd0);
    chk("rst_out_a",   32'({sb_a, sl_a}), 32'd0);
    chk("rst_min_a",   32'(mi_a), 32'd0);
    chk("rst_sel_a",   32'(ms_a), 32'd0);
    chk("rst_sel_b",   32'(ms_b), 32'd3);
    chk("rst_busy_b",  32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_frame(vt[i].w, vt[i].on_b, vt[i].seq, vt[i].cyc, vt[i].lat, 1'b0, 1'b0);

    // back-to-back frames, second word offered the moment word_ready returns
    run_frame(4'b1010, 1'b0, 4'b0101, 8, 1, 1'b0, 1'b0);
    t1 = last_acc;
    run_frame(4'b0101, 1'b0, 4'b1010, 8, 1, 1'b0, 1'b0);
    chk("b2b_gap_cycles", 32'((last_acc - t1) / 10), 32'd9);

    run_frame(4'b0110, 1'b0, 4'b0110, 11, 1, 1'b1, 1'b0);

    run_frame(4'b1100, 1'b0, 4'b0011, 8, 1, 1'b0, 1'b1);

    // reset while the second bit of 1111 is being presented
    use_b = 1'b0;
    @(negedge clk);
    word_in = 4'b1111;
    word_valid_a = 1'b1;
    push_frame(4'b1111, 1'b0);
    @(posedge clk);
    #1 word_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(sv_a), 32'd1);
    chk("pre_rst_sel",   32'(ms_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(sv_a), 32'd0);
    chk("mid_rst_busy",  32'(busy_a), 32'd0);
    chk("mid_rst_min",   32'(mi_a), 32'd0);
    chk("mid_rst_last",  32'(sl_a), 32'd0);
    sb.delete();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(4'b0011, 1'b0, 4'b1100, 8, 1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_scan_sequencer.md
Name: mux4_scan_sequencer

Overview:
- Upstream control stage for the team's 4:1 bit multiplexer.
- Accepts a 4-bit word over a valid/ready handshake and drives it onto the mux data inputs.
- Steps the mux select through all four positions, waiting a programmable settle time at each position.
- Samples the mux output after each settle and emits one bit per position as a serial stream with valid/ready flow control and an end-of-frame marker.

Parameters:
- DWELL, 1: settle cycles per select position before sampling. Legal range 1..16.
- MSB_FIRST, 0: 0 gives select order 00,01,10,11. 1 gives select order 11,10,01,00.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- word_in  input  4  word to scan.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept a word.
- mux_in  output  4  drives the data inputs of the 4:1 mux.
- mux_sel  output  2  drives the select input of the 4:1 mux.
- mux_out  input  1  output of the 4:1 mux (combinational from mux_in/mux_sel).
- ser_bit  output  1  sampled serial bit.
- ser_valid  output  1  ser_bit is valid.
- ser_last  output  1  ser_bit is the 4th bit of the frame.
- ser_ready  input  1  downstream accepts ser_bit.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - mux_in=0000, mux_sel=00 (11 if MSB_FIRST), ser_bit=0, ser_valid=0, ser_last=0, busy=0.
  - Dwell counter=0, bit index=0.
- Outputs are registered, except word_ready=(state==IDLE) and busy=(state!=IDLE).
- State machine, states IDLE, SETTLE, HOLD:
  - IDLE: word_ready=1. When word_valid=1 at a clock edge:
    - mux_in<=word_in.
    - mux_sel<=start index (00, or 11 if MSB_FIRST).
    - counter<=DWELL-1.
    - Go to SETTLE.
    - word_in is ignored whenever state≠IDLE.
  - SETTLE: counter decrements each cycle. At the edge where counter==0:
    - ser_bit<=mux_out, ser_valid<=1.
    - ser_last<=1 if this is the 4th position, else 0.
    - Go to HOLD.
  - HOLD: ser_bit, ser_last, mux_sel and mux_in are held stable while ser_ready=0. At the edge where ser_ready=1:
    - ser_valid<=0, ser_last<=0.
    - If the bit was last: go to IDLE. mux_in and mux_sel keep their values.
    - Otherwise: mux_sel steps +1 (or −1 if MSB_FIRST), counter<=DWELL-1, go to SETTLE.
- Timing with ser_ready held at 1:
  - Each bit occupies DWELL cycles in SETTLE plus 1 cycle in HOLD.
  - A frame takes 4*(DWELL+1) cycles from the accept edge to the return to IDLE.
  - The first ser_valid rises DWELL cycles after the accept edge.
- Back-to-back frames: the earliest next accept is the cycle after the last-bit handshake. There is one idle cycle in which word_ready=1.
- No bypass: a new word is never accepted in the same cycle as the last-bit handshake.
- mux_sel arithmetic is 2-bit and never wraps within a frame. The index counts exactly 4 positions.
- Reset mid-frame: all outputs return to their reset values immediately. The partial frame is discarded with no ser_last. The next accept is allowed after rst_n rises.
- ser_ready has no effect in IDLE or SETTLE.

Test Plan:
- DWELL=1, LSB first, word_in=1010, ser_ready=1 → mux_sel steps 00,01,10,11. ser_bit sequence is 0,1,0,1, each with ser_valid high for 1 cycle. ser_last is high only with the 4th bit. word_ready returns to 1 exactly 8 cycles after the accept edge.
- Back-to-back: 1010, then 0101 presented as soon as word_ready=1 → 8 bits 0,1,0,1,1,0,1,0. Exactly one IDLE cycle between frames. word_ready=0 for all other cycles.
- Backpressure: word 0110, ser_ready=0 for 3 cycles while bit 2 (value 1) is valid → ser_bit=1, ser_valid=1 and mux_sel=01 all held for those 3 cycles. Sequence then completes as 0,1,1,0 with no bit lost or duplicated.
- DWELL=3, MSB_FIRST=1, word 1000 → mux_sel order 11,10,01,00. Bits 1,0,0,0. First ser_valid 3 cycles after accept. Frame takes 16 cycles.
- Reset mid-frame: assert rst_n=0 while bit 2 of 1111 is valid → ser_valid=0 and busy=0 asynchronously, mux_in=0000. After release, word 0011 scans cleanly to 1,1,0,0.
- Input ignore: change word_in and hold word_valid=1 during a frame → the emitted bits reflect only the word latched at accept.
